// File: rtl/feature_log_packer.sv
// feature_log_packer
//   Accumulates a frame of unsigned spectral magnitudes into NUM_FEATURES bands
//   of BINS_PER_BAND consecutive bins each. When the frame ends, it emits one
//   Q8.8 log2 value per band on consecutive cycles. A frame that starts while
//   emission is in progress is dropped as a whole and reported once.
//
// Ports
//   clk_in            rising-edge clock
//   rst_in            asynchronous active-high reset
//   mag_data_in       unsigned magnitude of the current bin
//   mag_valid_in      mag_data_in is valid (no backpressure)
//   mag_last_in       the qualifying beat is the last bin of the frame
//   feature_data_out  signed Q8.8 log2 of the band energy
//   feature_valid_out feature_data_out is valid
//   feature_last_out  marks band NUM_FEATURES-1
//   frame_dropped_out one-cycle pulse when an input frame is discarded
module feature_log_packer #(
  parameter int NUM_FEATURES  = 16,
  parameter int BINS_PER_BAND = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [31:0]        mag_data_in,
  input  logic               mag_valid_in,
  input  logic               mag_last_in,
  output logic signed [15:0] feature_data_out,
  output logic               feature_valid_out,
  output logic               feature_last_out,
  output logic               frame_dropped_out
);

  localparam int          NUM_BINS = NUM_FEATURES * BINS_PER_BAND;
  localparam int          CNT_W    = $clog2(NUM_BINS + 1);
  localparam int          IDX_W    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned BPB      = BINS_PER_BAND;

  localparam logic [CNT_W-1:0] NUM_BINS_C = CNT_W'(NUM_BINS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_FEATURES - 1);

  typedef enum logic [1:0] {ACCUM, EMIT, DISCARD} state_t;

  state_t           state;
  logic [31:0]      acc [NUM_FEATURES];
  logic [CNT_W-1:0] bin_cnt;
  logic             in_frame;     // a frame has started and not yet ended
  logic [IDX_W-1:0] emit_idx;
  logic             issue_done;   // every band has entered the conversion pipe
  logic             intr_seen;    // a beat arrived while emitting
  logic             intr_last;    // ...and that intruding frame already ended
  logic             seen_nxt;
  logic             last_nxt;

  logic [IDX_W-1:0] band_idx;
  logic             bin_in_range;

  logic             vld_p1;
  logic             last_p1;
  logic [31:0]      sum_p1;

  // Unsigned add clamped at the 32-bit ceiling.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Q8.8 log2: integer part is the leading-one position, fraction is the
  // eight bits just below it (zero-filled for small values).
  function automatic logic signed [15:0] log2_q88(input logic [31:0] s);
    logic [4:0] p;
    logic [7:0] frac;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (s[i]) p = 5'(i);
    end
    frac = 8'({s, 8'h00} >> p);
    if (s == 32'h0) return 16'sh0000;
    return $signed({3'b000, p, frac});
  endfunction

  assign band_idx     = IDX_W'(32'(bin_cnt) / BPB);
  assign bin_in_range = (bin_cnt < NUM_BINS_C);

  // Include a beat landing on the very edge emission finishes.
  assign seen_nxt = intr_seen | mag_valid_in;
  assign last_nxt = intr_last | (mag_valid_in & mag_last_in);

  // ---- p0: frame control, band issue into the conversion pipe ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= ACCUM;
      bin_cnt           <= '0;
      in_frame          <= 1'b0;
      emit_idx          <= '0;
      issue_done        <= 1'b0;
      intr_seen         <= 1'b0;
      intr_last         <= 1'b0;
      vld_p1            <= 1'b0;
      last_p1           <= 1'b0;
      feature_valid_out <= 1'b0;
      feature_last_out  <= 1'b0;
      frame_dropped_out <= 1'b0;
    end else begin
      vld_p1            <= 1'b0;
      last_p1           <= 1'b0;
      frame_dropped_out <= 1'b0;
      feature_valid_out <= vld_p1;
      feature_last_out  <= vld_p1 & last_p1;
      case (state)
        ACCUM: begin
          if (mag_valid_in) begin
            if (!in_frame) begin
              bin_cnt  <= CNT_W'(1);
              in_frame <= 1'b1;
            end else if (bin_in_range) begin
              bin_cnt <= bin_cnt + CNT_W'(1);
            end
            if (mag_last_in) begin
              state      <= EMIT;
              in_frame   <= 1'b0;
              emit_idx   <= '0;
              issue_done <= 1'b0;
              intr_seen  <= 1'b0;
              intr_last  <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (!issue_done) begin
            vld_p1  <= 1'b1;
            last_p1 <= (emit_idx == LAST_IDX);
            if (emit_idx == LAST_IDX) issue_done <= 1'b1;
            else                      emit_idx   <= emit_idx + IDX_W'(1);
          end
          intr_seen <= seen_nxt;
          intr_last <= last_nxt;
          // Leave once the final feature reaches the output register.
          if (vld_p1 && last_p1) begin
            frame_dropped_out <= seen_nxt;
            state             <= (seen_nxt && !last_nxt) ? DISCARD : ACCUM;
          end
        end
        DISCARD: begin
          if (mag_valid_in && mag_last_in) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // ---- p0: band accumulators (cleared by the first beat of each frame) ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int b = 0; b < NUM_FEATURES; b++) acc[b] <= 32'h0;
    end else if (state == ACCUM && mag_valid_in) begin
      if (!in_frame) begin
        for (int b = 0; b < NUM_FEATURES; b++) acc[b] <= (b == 0) ? mag_data_in : 32'h0;
      end else if (bin_in_range) begin
        acc[band_idx] <= sat_add32(acc[band_idx], mag_data_in);
      end
    end
  end

  // ---- p1: selected band sum ----
  always_ff @(posedge clk_in) begin
    if (state == EMIT && !issue_done) sum_p1 <= acc[emit_idx];
  end

  // ---- p2: log conversion into the held output register ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      feature_data_out <= 16'sh0000;
    else if (vld_p1) feature_data_out <= log2_q88(sum_p1);
  end

endmodule

// File: doc/feature_log_packer.md
FEATURE_LOG_PACKER -- requirements
Module: feature_log_packer

Interface
REQ-001 SHALL have parameter NUM_FEATURES, default 16, giving the number of bands (features) emitted per frame.
REQ-002 SHALL have parameter BINS_PER_BAND, default 8, giving the number of consecutive input bins summed into one band; NUM_BINS = NUM_FEATURES*BINS_PER_BAND.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port mag_data_in, input, 32 bits: unsigned spectral magnitude of the current bin.
REQ-006 SHALL have port mag_valid_in, input, 1 bit: mag_data_in is valid this cycle; there is no backpressure.
REQ-007 SHALL have port mag_last_in, input, 1 bit: the qualifying beat is the last bin of the frame.
REQ-008 SHALL have port feature_data_out, output, 16 bits signed: log2 band energy in Q8.8.
REQ-009 SHALL have port feature_valid_out, output, 1 bit: feature_data_out is valid.
REQ-010 SHALL have port feature_last_out, output, 1 bit: marks feature index NUM_FEATURES-1.
REQ-011 SHALL have port frame_dropped_out, output, 1 bit: one-cycle pulse when an input frame is discarded.

Function
REQ-012 SHALL have states ACCUM, EMIT and DISCARD.
REQ-013 In ACCUM, the first valid beat of a frame SHALL clear all band accumulators and the bin counter before that beat is summed.
REQ-014 In ACCUM, each valid beat at bin k SHALL add to band k/BINS_PER_BAND with a saturating 32-bit sum (clamped at 0xFFFFFFFF); the bin counter then increments.
REQ-015 Beats with bin counter >= NUM_BINS SHALL be ignored and cause no error; the counter saturates.
REQ-016 When mag_last_in is accepted in ACCUM, the state SHALL become EMIT; that beat is summed first (if within range); a short frame emits its partial sums, and unfilled bands read 0.
REQ-017 Log conversion, for sum S != 0 with p = index of the leading one (0..31): bits[15:13]=0, bits[12:8]=p, bits[7:0]=the 8 bits directly below the leading one, zero-filled when p<8.
REQ-018 Log conversion for S = 0 SHALL give 0x0000.
REQ-019 The conversion SHALL be pipelined; the first feature_valid_out SHALL be asserted exactly 2 cycles after the cycle mag_last_in was accepted.
REQ-020 Features SHALL be emitted in band order 0..NUM_FEATURES-1 on NUM_FEATURES consecutive cycles with feature_valid_out high, and feature_last_out high only with the last one.
REQ-021 After the last feature, the state SHALL return to ACCUM on the next cycle, ready for a new frame.
REQ-022 A mag_valid_in beat arriving in EMIT SHALL move the state to DISCARD once emission completes, and frame_dropped_out SHALL pulse once for that frame.
REQ-023 Emission in progress SHALL never be interrupted or altered by input activity.
REQ-024 In DISCARD, all beats SHALL be ignored until mag_last_in is accepted; the state then returns to ACCUM.
REQ-025 If mag_last_in of the intruding frame arrives during EMIT, the state SHALL return directly to ACCUM after emission and skip DISCARD.
REQ-026 feature_data_out SHALL hold its last value when feature_valid_out is low.

Reset
REQ-027 On assertion of rst_in at any time, including mid-frame or mid-emission, the block SHALL asynchronously force state ACCUM, clear the bin counter and the accumulators, and drive feature_valid_out=0, feature_last_out=0, frame_dropped_out=0 and feature_data_out=0x0000.
REQ-028 After rst_in deasserts, a partially received frame SHALL NOT be emitted; the next valid beat starts a new frame.

Verification
REQ-029 Full frame: 128 beats with all mag_data_in=1 and last on beat 127 -> each band sum=8, every feature=0x0300, valid 2 cycles after last for 16 cycles, last on the 16th.
REQ-030 Fraction and zero: band 0 bins sum to 0x00000180, band 1 all zero -> feature0=0x0880, feature1=0x0000.
REQ-031 Saturation: band 15 bins each 0xFFFFFFFF -> feature15=0x1FFF.
REQ-032 Overlap: a new frame starts 3 cycles into EMIT with its last beat after emission -> the first 16 features are intact, frame_dropped_out pulses once, and the dropped frame produces no output; the following frame emits normally.
REQ-033 Short frame: last on beat 9 with all inputs=4 -> features 0x0500, 0x0300, then 14x 0x0000.
REQ-034 Reset at cycle 5 of EMIT -> outputs are 0 immediately; no further valid until a new full frame is received.
